// File: rtl/sym_seq_detector_pkg.sv
// Shared definitions for the symbol sequence detector: symbol width, FSM
// encodings and the fill-counter width helper.
package sym_seq_pkg;

    localparam int SYM_W = 2;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_ARMED   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY   = ST_EMPTY,
        S_FILLING = ST_FILLING,
        S_ARMED   = ST_ARMED
    } state_t;

    // The fill counter has to hold the values 0..n inclusive.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sym_seq_detector_if.sv
// Symbol/pattern/status bundle between the symbol source and the detector.
// master drives symbols and control; slave is the detector.
interface sym_seq_detector_if #(
    parameter int N_SYM = 4,
    parameter int CNT_W = 8
) ();

    logic                 load_pat;
    logic [2*N_SYM-1:0]   pat_in;
    logic                 sym_valid;
    logic [1:0]           sym_in;
    logic                 clear_cnt;
    logic                 match;
    logic [CNT_W-1:0]     match_cnt;
    logic                 cnt_sat;
    logic                 window_full;

    modport master (
        output load_pat, pat_in, sym_valid, sym_in, clear_cnt,
        input  match, match_cnt, cnt_sat, window_full
    );

    modport slave (
        input  load_pat, pat_in, sym_valid, sym_in, clear_cnt,
        output match, match_cnt, cnt_sat, window_full
    );

endinterface

// File: rtl/sym_seq_detector_sym_eq.sv
// Combinational equality of one window symbol against one pattern symbol.
module sym_eq_2bit
    import sym_seq_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/sym_seq_detector.sv
// Sliding-window detector for a programmable N_SYM-symbol pattern with
// overlapping matches, a registered match pulse and a saturating hit counter.
module sym_seq_detector
    import sym_seq_pkg::*;
#(
    parameter int N_SYM = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    sym_seq_detector_if.slave bus
);

    localparam int                WIN_W    = SYM_W * N_SYM;
    localparam int                FILL_W   = fill_width(N_SYM);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N_SYM);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WIN_W-1:0]  pattern_q;
    logic [WIN_W-1:0]  window_q;
    logic [WIN_W-1:0]  window_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    state_t            state_q;
    logic              match_q;
    logic              full_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              sat_q;
    logic              accept;
    logic              hit;
    logic [N_SYM-1:0]  slot_eq;

    // A load in the same cycle as a symbol wins; the symbol is dropped.
    assign accept      = bus.sym_valid & ~bus.load_pat;
    assign window_next = {window_q[WIN_W-SYM_W-1:0], bus.sym_in};
    assign fill_next   = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    assign cnt_inc     = cnt_q + CNT_W'(1);

    // Compare against the post-shift window so the new symbol takes part.
    for (genvar i = 0; i < N_SYM; i++) begin : g_slot
        sym_eq_2bit u_eq (
            .a  (window_next[SYM_W*i +: SYM_W]),
            .b  (pattern_q[SYM_W*i +: SYM_W]),
            .eq (slot_eq[i])
        );
    end

    assign hit = (&slot_eq) && (fill_next == FILL_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            window_q  <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            state_q   <= S_EMPTY;
            match_q   <= 1'b0;
        end else if (bus.load_pat) begin
            pattern_q <= bus.pat_in;
            window_q  <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            state_q   <= S_EMPTY;
            match_q   <= 1'b0;
        end else if (accept) begin
            window_q <= window_next;
            match_q  <= hit;
            case (state_q)
                S_EMPTY, S_FILLING: begin
                    fill_q  <= fill_next;
                    full_q  <= (fill_next == FILL_MAX);
                    state_q <= (fill_next == FILL_MAX) ? S_ARMED : S_FILLING;
                end
                S_ARMED: begin
                    state_q <= S_ARMED;
                end
                default: begin
                    fill_q  <= '0;
                    full_q  <= 1'b0;
                    state_q <= S_EMPTY;
                end
            endcase
        end else begin
            match_q <= 1'b0;
        end
    end

    // Counter follows the registered pulse; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || bus.clear_cnt) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (match_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == CNT_MAX) begin
                    sat_q <= 1'b1;
                end
            end else begin
                sat_q <= 1'b1;
            end
        end
    end

    assign bus.match       = match_q;
    assign bus.match_cnt   = cnt_q;
    assign bus.cnt_sat     = sat_q;
    assign bus.window_full = full_q;

endmodule
